pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/load_use_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   ctrl_state_e : sequencer state encoding (RUN=0, DMEM_WAIT=1, HALT_DRAIN=2, HALTED=3)
//   REG_ZERO     : architectural zero register, never a hazard source
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StDmemWait  = 2'd1,
    StHaltDrain = 2'd2,
    StHalted    = 2'd3
  } ctrl_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the instruction in ID reads.
// Ports:
//   rs_ID, rt_ID             source registers of the ID instruction
//   rs_used_ID, rt_used_ID   which sources are actually read
//   wr_reg_EX                destination of the EX instruction
//   rf_we_EX, dm_rd_en_EX    EX instruction writes the RF / is a load
//   hazard                   one-bubble stall required
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 4
) (
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             rs_used_ID,
  input  logic             rt_used_ID,
  input  logic [REG_W-1:0] wr_reg_EX,
  input  logic             rf_we_EX,
  input  logic             dm_rd_en_EX,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = rs_used_ID && (rs_ID == wr_reg_EX);
    rt_hit = rt_used_ID && (rt_ID == wr_reg_EX);
    hazard = dm_rd_en_EX && rf_we_EX && (wr_reg_EX != REG_W'(REG_ZERO)) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Outputs are combinational so that a
// hazard stalls the pipe registers in the same cycle it is detected.
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating stall_cnt / flush_cnt counters.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   rs_ID..hlt_ID                       ID-stage operand usage and HLT decode
//   wr_reg_EX..br_taken_EX              EX-stage destination, load flag, taken branch
//   dm_access_MEM, dmem_rdy             MEM-stage access and data-memory handshake
//   hlt_WB                              HLT has retired
//   pc_we..mem_wb_we                    pipe register load enables
//   if_id_flush..mem_wb_flush           load a bubble
//   halted, mem_err                     sticky status
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
`ifdef PIPE_CTRL_PERF_EN
  parameter int unsigned CNT_W  = 16,
`endif
  parameter int unsigned REG_W  = 4,
  parameter int unsigned MEM_TO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             rs_used_ID,
  input  logic             rt_used_ID,
  input  logic             hlt_ID,
  input  logic [REG_W-1:0] wr_reg_EX,
  input  logic             rf_we_EX,
  input  logic             dm_rd_en_EX,
  input  logic             br_taken_EX,
  input  logic             dm_access_MEM,
  input  logic             dmem_rdy,
  input  logic             hlt_WB,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             mem_err
);

  localparam int unsigned TO_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

  ctrl_state_e     state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ret_drain_q, ret_drain_d;  // DMEM_WAIT returns to HALT_DRAIN
  logic            mem_err_q, mem_err_d;
  logic            lu_hazard;
  logic            do_freeze, do_run, do_drain;
  logic            br_flush;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use_detect (
    .rs_ID      (rs_ID),
    .rt_ID      (rt_ID),
    .rs_used_ID (rs_used_ID),
    .rt_used_ID (rt_used_ID),
    .wr_reg_EX  (wr_reg_EX),
    .rf_we_EX   (rf_we_EX),
    .dm_rd_en_EX(dm_rd_en_EX),
    .hazard     (lu_hazard)
  );

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    ret_drain_d  = ret_drain_q;
    mem_err_d    = mem_err_q;
    do_freeze    = 1'b0;
    do_run       = 1'b0;
    do_drain     = 1'b0;
    br_flush     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (dm_access_MEM && !dmem_rdy) begin
          do_freeze   = 1'b1;
          state_d     = StDmemWait;
          ret_drain_d = 1'b0;
        end else begin
          do_run = 1'b1;
        end
      end
      StDmemWait: begin
        if (!dmem_rdy) begin
          do_freeze = 1'b1;
        end else begin
          // Release cycle: the held EX/ID contents are acted on now.
          to_cnt_d = '0;
          if (ret_drain_q) begin
            do_drain = 1'b1;
          end else begin
            do_run = 1'b1;
          end
        end
      end
      StHaltDrain: begin
        if (!hlt_WB && dm_access_MEM && !dmem_rdy) begin
          do_freeze   = 1'b1;
          state_d     = StDmemWait;
          ret_drain_d = 1'b1;
        end else begin
          do_drain = 1'b1;
        end
      end
      StHalted: begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        mem_wb_we = 1'b0;
      end
      default: state_d = StRun;
    endcase

    if (do_freeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
      // Counter holds the number of stalled cycles so far; it saturates at the limit.
      if (to_cnt_q == TO_W'(MEM_TO - 1)) begin
        mem_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    if (do_run) begin
      state_d = StRun;
      if (br_taken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        br_flush    = 1'b1;
      end else if (lu_hazard) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (hlt_ID) begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
        state_d     = StHaltDrain;
      end
    end

    if (do_drain) begin
      if (hlt_WB) begin
        // Retiring HLT is older than any branch in EX.
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
        state_d     = StHalted;
      end else if (br_taken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        br_flush    = 1'b1;
        state_d     = StRun;
      end else begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
        state_d     = StHaltDrain;
      end
    end

    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      br_flush     = 1'b0;
    end

    halted  = rst_n && (state_q == StHalted);
    mem_err = rst_n && mem_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      to_cnt_q    <= '0;
      ret_drain_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      ret_drain_q <= ret_drain_d;
      mem_err_q   <= mem_err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_evt;

  always_comb begin
    stall_evt = !pc_we && ((state_q == StRun) || (state_q == StDmemWait));
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TO=4). Inputs change 1ns after the rising edge,
// outputs are checked on the falling edge. Output vector order:
// {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush, mem_wb_flush,
//  halted, mem_err}
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] V_RST  = 10'b00000_000_00;
  localparam logic [9:0] V_DEF  = 10'b11111_000_00;
  localparam logic [9:0] V_LU   = 10'b00111_010_00;
  localparam logic [9:0] V_BR   = 10'b11111_110_00;
  localparam logic [9:0] V_FRZ  = 10'b00001_001_00;
  localparam logic [9:0] V_FRZE = 10'b00001_001_01;
  localparam logic [9:0] V_DEFE = 10'b11111_000_01;
  localparam logic [9:0] V_HLT  = 10'b01111_100_00;
  localparam logic [9:0] V_HLTD = 10'b00000_000_10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rs_ID, rt_ID, wr_reg_EX;
  logic       rs_used_ID, rt_used_ID, hlt_ID, rf_we_EX, dm_rd_en_EX, br_taken_EX;
  logic       dm_access_MEM, dmem_rdy, hlt_WB;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W (4),
    .MEM_TO(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_ID        (rs_ID),
    .rt_ID        (rt_ID),
    .rs_used_ID   (rs_used_ID),
    .rt_used_ID   (rt_used_ID),
    .hlt_ID       (hlt_ID),
    .wr_reg_EX    (wr_reg_EX),
    .rf_we_EX     (rf_we_EX),
    .dm_rd_en_EX  (dm_rd_en_EX),
    .br_taken_EX  (br_taken_EX),
    .dm_access_MEM(dm_access_MEM),
    .dmem_rdy     (dmem_rdy),
    .hlt_WB       (hlt_WB),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .mem_err      (mem_err)
  );

  task automatic idle();
    rs_ID = 4'd0; rt_ID = 4'd0; wr_reg_EX = 4'd0;
    rs_used_ID = 1'b0; rt_used_ID = 1'b0; hlt_ID = 1'b0;
    rf_we_EX = 1'b0; dm_rd_en_EX = 1'b0; br_taken_EX = 1'b0;
    dm_access_MEM = 1'b0; dmem_rdy = 1'b1; hlt_WB = 1'b0;
  endtask

  task automatic load_use(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] wr,
                          input logic rs_u, input logic rt_u);
    rs_ID = rs; rt_ID = rt; wr_reg_EX = wr; rs_used_ID = rs_u; rt_used_ID = rt_u;
    rf_we_EX = 1'b1; dm_rd_en_EX = 1'b1;
  endtask

  // Check the outputs in the current cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    @(negedge clk);
    obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc("reset", V_RST);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();
    cyc("idle", V_DEF);

    // LW R3 in EX, ADD R4,R3,R1 in ID: one bubble, then the load has moved on.
    load_use(4'd3, 4'd1, 4'd3, 1'b1, 1'b1);
    cyc("lu_rs", V_LU);
    idle();
    cyc("lu_after", V_DEF);
    load_use(4'd0, 4'd1, 4'd0, 1'b1, 1'b1);
    cyc("lu_r0", V_DEF);
    load_use(4'd2, 4'd5, 4'd5, 1'b1, 1'b1);
    cyc("lu_rt", V_LU);
    load_use(4'd2, 4'd5, 4'd5, 1'b1, 1'b0);
    cyc("lu_rt_unused", V_DEF);
    load_use(4'd3, 4'd1, 4'd3, 1'b1, 1'b1);
    rf_we_EX = 1'b0;
    cyc("lu_no_we", V_DEF);

    // Branch beats load-use.
    load_use(4'd3, 4'd1, 4'd3, 1'b1, 1'b1);
    br_taken_EX = 1'b1;
    cyc("br_over_lu", V_BR);
    idle();
    br_taken_EX = 1'b1;
    cyc("br_only", V_BR);

    // 3-cycle DMEM stall with a held taken branch; branch acts on release.
    idle();
    dm_access_MEM = 1'b1; dmem_rdy = 1'b0; br_taken_EX = 1'b1;
    cyc("dmem_frz0", V_FRZ);
    cyc("dmem_frz1", V_FRZ);
    cyc("dmem_frz2", V_FRZ);
    dmem_rdy = 1'b1;
    cyc("dmem_release_br", V_BR);
    idle();
    cyc("dmem_after", V_DEF);

    // Timeout: mem_err appears after 4 stalled cycles and is sticky.
    dm_access_MEM = 1'b1; dmem_rdy = 1'b0;
    cyc("to_frz0", V_FRZ);
    cyc("to_frz1", V_FRZ);
    cyc("to_frz2", V_FRZ);
    cyc("to_frz3", V_FRZ);
    cyc("to_err", V_FRZE);
    dmem_rdy = 1'b1;
    cyc("to_release", V_DEFE);
    idle();
    cyc("to_sticky", V_DEFE);

    // Reset while in DMEM_WAIT clears everything.
    dm_access_MEM = 1'b1; dmem_rdy = 1'b0;
    cyc("rw_frz", V_FRZE);
    do_reset();
    cyc("rw_run", V_DEF);

    // HLT drain then halted.
    hlt_ID = 1'b1;
    cyc("hlt_id", V_HLT);
    idle();
    cyc("drain1", V_HLT);
    cyc("drain2", V_HLT);
    hlt_WB = 1'b1;
    cyc("drain3_wb", V_HLT);
    idle();
    cyc("halted", V_HLTD);
    br_taken_EX = 1'b1; hlt_ID = 1'b1;
    cyc("halted_hold", V_HLTD);

    // Older branch squashes the HLT.
    do_reset();
    hlt_ID = 1'b1;
    cyc("sq_hlt", V_HLT);
    idle();
    br_taken_EX = 1'b1;
    cyc("sq_br", V_BR);
    idle();
    cyc("sq_run", V_DEF);

    // hlt_WB beats br_taken_EX during drain.
    hlt_ID = 1'b1;
    cyc("wb_hlt", V_HLT);
    idle();
    hlt_WB = 1'b1; br_taken_EX = 1'b1;
    cyc("wb_over_br", V_HLT);
    idle();
    cyc("wb_halted", V_HLTD);

    // DMEM stall during drain returns to HALT_DRAIN.
    do_reset();
    hlt_ID = 1'b1;
    cyc("dd_hlt", V_HLT);
    idle();
    dm_access_MEM = 1'b1; dmem_rdy = 1'b0;
    cyc("dd_frz0", V_FRZ);
    cyc("dd_frz1", V_FRZ);
    dmem_rdy = 1'b1;
    cyc("dd_release", V_HLT);
    idle();
    cyc("dd_drain", V_HLT);
    hlt_WB = 1'b1;
    cyc("dd_wb", V_HLT);
    idle();
    cyc("dd_halted", V_HLTD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
